// File: rtl/mem_bus_pkg.sv
// Shared types and sizes for the two-requester MAR/MDR system-bus controller.
package mem_bus_pkg;
    localparam int WORD_W  = 8;
    localparam int OP_W    = 3;
    localparam int ADDR_W  = WORD_W - OP_W;
    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ACCESS,
        READ,
        DONE
    } state_e;
endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Requester-side handshake bundle: per-requester request/command inputs and
// the controller's grant/done/read-data responses.
interface mem_bus_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 5
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [WORD_W-1:0] wdata0;
    logic [WORD_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [WORD_W-1:0] rdata;
    logic              busy;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1,
        output gnt, done, rdata, busy
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1,
        input  gnt, done, rdata, busy
    );
endinterface

// File: rtl/mem_bus_ctrl_arb2.sv
// Two-way request arbiter. MEM_BUS_RR_EN selects round-robin tie breaking;
// otherwise requester 0 always wins a tie.
module arb2
    import mem_bus_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic               grant_valid,
    output logic               winner
);
    logic prio;

`ifdef MEM_BUS_RR_EN
    logic last_q;
    logic last_d;

    assign last_d = take ? winner : last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // The requester not served last gets the tie.
    assign prio = ~last_q;
`else
    logic unused_rr;
    assign unused_rr = ^{clock, reset, take};
    assign prio      = 1'b0;
`endif

    assign grant_valid = |req;
    assign winner      = (&req) ? prio : req[1];
endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences CPU / debug-port transactions onto the MAR/MDR system bus.
// Define MEM_BUS_RR_EN for round-robin arbitration (fixed priority otherwise).
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_ctrl_if.slave     bus,
    output logic              load_MAR,
    output logic              load_MDR,
    output logic              CS,
    output logic              R_NW,
    output logic              MDR_bus,
    inout  wire  [WORD_W-1:0] sysbus
);
    localparam int ADDR_W = WORD_W - OP_W;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    logic              grant_valid;
    logic              winner;
    logic              take;
    logic              bus_oe;
    logic [WORD_W-1:0] bus_out;

    arb2 u_arb (
        .clock       (clock),
        .reset       (reset),
        .req         (bus.req),
        .take        (take),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    take    = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR:    state_d = we_q ? DATA : ACCESS;
            DATA:    state_d = ACCESS;
            ACCESS:  state_d = we_q ? DONE : READ;
            READ:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command fields are captured once at grant so late requester changes are ignored.
    always_comb begin
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (take) begin
            owner_d = winner;
            we_d    = bus.we[winner];
            addr_d  = winner ? bus.addr1  : bus.addr0;
            wdata_d = winner ? bus.wdata1 : bus.wdata0;
        end
    end

    assign rdata_d = (state_q == READ) ? sysbus : rdata_q;

    always_comb begin
        load_MAR = 1'b0;
        load_MDR = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b1;
        MDR_bus  = 1'b0;
        case (state_q)
            ADDR:    load_MAR = 1'b1;
            DATA:    load_MDR = 1'b1;
            ACCESS: begin
                CS   = 1'b1;
                R_NW = ~we_q;
            end
            READ:    MDR_bus = 1'b1;
            default: ;
        endcase
    end

    assign bus_oe  = (state_q == ADDR) || (state_q == DATA);
    assign bus_out = (state_q == ADDR) ? {{OP_W{1'b0}}, addr_q} : wdata_q;
    assign sysbus  = bus_oe ? bus_out : {WORD_W{1'bz}};

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
            assign bus.gnt[gi]  = (state_q != IDLE) && (owner_q == 1'(gi));
            assign bus.done[gi] = (state_q == DONE) && (owner_q == 1'(gi));
        end
    endgenerate

    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: a RAM peripheral on sysbus plus a transaction-level
// expectation model compared against the outputs on every cycle.
module tb_mem_bus_ctrl;
`ifdef MEM_BUS_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_bus_ctrl_if #(.WORD_W(8), .ADDR_W(5)) bif ();

    logic       load_MAR, load_MDR, CS, R_NW, MDR_bus;
    wire  [7:0] sysbus;

    mem_bus_ctrl #(.WORD_W(8), .OP_W(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bif),
        .load_MAR (load_MAR),
        .load_MDR (load_MDR),
        .CS       (CS),
        .R_NW     (R_NW),
        .MDR_bus  (MDR_bus),
        .sysbus   (sysbus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    // RAM peripheral: 16 words addressed by the low MAR bits.
    logic [7:0] ram [16] = '{default: 8'h00};
    logic [3:0] mar = 4'h0;
    logic [7:0] mdr = 8'h00;

    always @(posedge clock) begin
        if (load_MAR) mar <= sysbus[3:0];
        if (load_MDR) mdr <= sysbus;
        if (CS && !R_NW) ram[mar] <= mdr;
    end

    typedef struct packed {
        logic       mar, mdr, cs, rnw, mdrb, drive, busy, rd_done, wr_done;
        logic [1:0] gnt, done;
        logic [7:0] bus;
    } exp_t;

    function automatic exp_t idle_c();
        exp_t e;
        e     = '0;
        e.rnw = 1'b1;
        return e;
    endfunction

    exp_t       q[$];
    exp_t       cur = '0;
    logic       model_ok = 1'b0;
    logic       last_own = 1'b1;
    logic [7:0] exp_mem [16] = '{default: 8'h00};
    logic [7:0] exp_rdata = 8'h00;
    logic       t_we;
    logic [4:0] t_addr;
    logic [7:0] t_data;

    // Bench side of the bus: peripheral read data in READ, a 0 keeper elsewhere.
    logic       keep_en;
    logic [7:0] keep_val;
    assign keep_en  = !cur.drive;
    assign keep_val = MDR_bus ? ram[mar] : 8'h00;
    assign sysbus   = keep_en ? keep_val : 8'bz;

    initial begin
        exp_t e, a;
        logic w;
        cur = idle_c();
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                q.delete();
                cur       = idle_c();
                exp_rdata = 8'h00;
                last_own  = 1'b1;
                model_ok  = 1'b1;
            end else begin
                if (q.size() == 0 && !cur.busy && bif.req != 2'b00) begin
                    if (bif.req == 2'b11) w = RR ? ~last_own : 1'b0;
                    else                  w = bif.req[1];
                    last_own = w;
                    t_we   = bif.we[w];
                    t_addr = w ? bif.addr1  : bif.addr0;
                    t_data = w ? bif.wdata1 : bif.wdata0;
                    e      = idle_c();
                    e.busy = 1'b1;
                    e.gnt  = w ? 2'b10 : 2'b01;
                    a = e; a.mar = 1'b1; a.drive = 1'b1; a.bus = {3'b000, t_addr};
                    q.push_back(a);
                    if (t_we) begin
                        a = e; a.mdr = 1'b1; a.drive = 1'b1; a.bus = t_data;
                        q.push_back(a);
                    end
                    a = e; a.cs = 1'b1; a.rnw = !t_we;
                    q.push_back(a);
                    if (!t_we) begin
                        a = e; a.mdrb = 1'b1; a.bus = exp_mem[t_addr[3:0]];
                        q.push_back(a);
                    end
                    a = e; a.done = e.gnt; a.rd_done = !t_we; a.wr_done = t_we;
                    q.push_back(a);
                    q.push_back(idle_c());
                end
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    if (cur.rd_done) exp_rdata = exp_mem[t_addr[3:0]];
                    if (cur.wr_done) exp_mem[t_addr[3:0]] = t_data;
                end else begin
                    cur = idle_c();
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (model_ok) begin
                chk("load_MAR", load_MAR, cur.mar);
                chk("load_MDR", load_MDR, cur.mdr);
                chk("CS", CS, cur.cs);
                chk("R_NW", R_NW, cur.rnw);
                chk("MDR_bus", MDR_bus, cur.mdrb);
                chk("gnt", bif.gnt, cur.gnt);
                chk("done", bif.done, cur.done);
                chk("busy", bif.busy, cur.busy);
                chk("rdata", bif.rdata, exp_rdata);
                chk("sysbus", sysbus, cur.bus);
                chk("strobe_excl", $onehot0({load_MAR, load_MDR, CS, MDR_bus}), 1);
            end
        end
    end

    // Runs until done pulses; lat counts granted cycles including the done cycle.
    task automatic txn(input bit scramble, output int lat, output logic [1:0] g);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        g    = 2'b00;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (bif.gnt != 2'b00) begin
                lat++;
                if (scramble && lat == 1) begin
                    bif.addr0  = 5'h07;
                    bif.wdata0 = 8'h3C;
                end
            end
            if (bif.done != 2'b00) begin
                seen = 1'b1;
                g    = bif.gnt;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout actual no_done required done_within_20");
        end
    endtask

    initial begin
        int         lat, dcnt;
        logic [1:0] g;
        logic [1:0] order [3];
        bit         hit;

        bif.req = 2'b00; bif.we = 2'b00;
        bif.addr0 = '0; bif.addr1 = '0; bif.wdata0 = '0; bif.wdata1 = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_rdata", bif.rdata, 8'h00);
        chk("rst_rnw", R_NW, 1);
        chk("rst_gnt", bif.gnt, 2'b00);

        bif.we = 2'b01; bif.addr0 = 5'h12; bif.wdata0 = 8'hA5; bif.req = 2'b01;
        txn(1'b1, lat, g);
        bif.req = 2'b00;
        $display("txn write  gnt=%b lat=%0d ram[2]=%h", g, lat, ram[2]);
        chk("wr_latency", lat, 4);
        chk("wr_gnt", g, 2'b01);
        chk("ram_2", ram[2], 8'hA5);

        @(negedge clock);
        bif.we = 2'b00; bif.addr0 = 5'h12; bif.req = 2'b01;
        txn(1'b0, lat, g);
        bif.req = 2'b00;
        $display("txn read   gnt=%b lat=%0d rdata=%h", g, lat, bif.rdata);
        chk("rd_latency", lat, 4);
        chk("rd_rdata", bif.rdata, 8'hA5);

        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bif.we = 2'b00; bif.addr0 = 5'h01; bif.addr1 = 5'h02; bif.req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            txn(1'b0, lat, g);
            order[k] = g;
            $display("txn tie%0d  gnt=%b lat=%0d rdata=%h", k, g, lat, bif.rdata);
        end
        bif.req = 2'b00;
        chk("tie_0", order[0], 2'b01);
        chk("tie_1", order[1], RR ? 2'b10 : 2'b01);
        chk("tie_2", order[2], 2'b01);

        @(negedge clock);
        bif.we = 2'b00; bif.addr1 = 5'h03; bif.req = 2'b10;
        dcnt = 0;
        hit  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bif.done[1]) dcnt++;
            if (CS && !hit) begin
                bif.req = 2'b00;
                hit     = 1'b1;
            end
        end
        $display("txn drop   done1_pulses=%0d", dcnt);
        chk("drop_done_cnt", dcnt, 1);

        bif.we = 2'b01; bif.addr0 = 5'h12; bif.wdata0 = 8'h5A; bif.req = 2'b01;
        dcnt = 0;
        hit  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bif.done != 2'b00) dcnt++;
            if (hit && reset) begin
                reset = 1'b0;
                chk("rstmid_busy", bif.busy, 0);
                chk("rstmid_strobes", {load_MAR, load_MDR, CS, MDR_bus}, 4'b0000);
                chk("rstmid_rnw", R_NW, 1);
            end else if (load_MDR && !hit) begin
                reset   = 1'b1;
                bif.req = 2'b00;
                hit     = 1'b1;
            end
        end
        $display("txn rstmid hit=%0d done_pulses=%0d ram[2]=%h", hit, dcnt, ram[2]);
        chk("rstmid_hit", hit, 1);
        chk("rstmid_done", dcnt, 0);
        chk("rstmid_ram", ram[2], 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Shares the single MAR/MDR system bus (RAM, register, buffer, switch peripherals) between two requesters: requester 0 is the CPU sequencer, requester 1 is the debug/DMA port.
- Sequences each read or write transaction into the bus strobes: load_MAR, load_MDR, CS, R_NW, MDR_bus.
- Drives address and write data onto sysbus and captures read data from it.

Parameters:
- WORD_W, 8, bus/data word width.
- OP_W, 3, opcode field width; address width ADDR_W = WORD_W-OP_W (5).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  per-requester transaction request; held high until that requester's done.
- we  input  2  per-requester write enable (1 = write, 0 = read); sampled at grant.
- addr0, addr1  input  ADDR_W  per-requester address; sampled at grant.
- wdata0, wdata1  input  WORD_W  per-requester write data; sampled at grant.
- gnt  output  2  one-hot; owner of the current transaction.
- done  output  2  one-cycle pulse to the owner at transaction end.
- rdata  output  WORD_W  read data; valid when done pulses for a read.
- busy  output  1  high in any state other than IDLE.
- load_MAR, load_MDR, CS, R_NW, MDR_bus  output  1 each  peripheral bus strobes.
- sysbus  inout  WORD_W  shared system bus; driven only when bus_oe is internally high, otherwise Z.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, gnt=0, done=0, rdata=0, busy=0, load_MAR=load_MDR=CS=MDR_bus=0, R_NW=1, sysbus=Z.
- FSM states: IDLE, ADDR, DATA, ACCESS, READ, DONE. Strobes are a Moore decode of the registered state.
- IDLE: if any req bit is set, the arbiter picks a winner. In the same edge the controller latches we/addr/wdata of the winner, sets gnt, and goes to ADDR.
- ADDR: sysbus = {OP_W'b0, addr_l}; load_MAR=1. Next state is DATA if we_l, else ACCESS.
- DATA (write only): sysbus = wdata_l; load_MDR=1. Next state is ACCESS.
- ACCESS: CS=1; R_NW = ~we_l. Next state is READ if read, else DONE.
- READ: MDR_bus=1 with sysbus released. rdata <= sysbus on the exiting edge. Next state is DONE.
- DONE: done[owner]=1 for this cycle only. gnt is cleared on exit. Next state is IDLE.
- Latency, grant edge to done cycle: write 4 cycles (ADDR, DATA, ACCESS, DONE); read 4 cycles (ADDR, ACCESS, READ, DONE). Minimum back-to-back spacing is 5 cycles because IDLE is always visited.
- R_NW=1 in every state except write-ACCESS. sysbus is driven only in ADDR and DATA, never in READ, so there is no contention with peripherals.
- Simultaneous requests in IDLE are resolved by arbitration (see Optional Feature).
- Requester drops req mid-transaction: the transaction still completes and done still pulses; there is no abort.
- New or changed inputs after grant are ignored (latched copies are used).
- Reset asserted mid-transaction: on the next edge the FSM returns to IDLE, all strobes deassert, and the bus tri-states. The pending done is never issued.
- done and rdata hold no state across transactions except rdata, which retains the last read value.

Optional Feature:
- Macro MEM_BUS_RR_EN.
- Defined: round-robin. A 1-bit last-owner register (reset 1, so requester 0 wins the first tie) flips priority after each grant; on a tie the requester not granted last wins.
- Undefined: fixed priority, requester 0 always wins ties. The last-owner register is not instantiated.

Decomposition:
- Package mem_bus_pkg: state enum (IDLE, ADDR, DATA, ACCESS, READ, DONE); localparams ADDR_W and the number of requesters (2).
- Sub-module arb2: combinational winner select plus the optional last-owner register. Input is req; outputs are grant_valid and winner index.
- The FSM, latches, and bus drive stay in mem_bus_ctrl.

Test Plan:
- Write: req0, we=1, addr0=5'h12, wdata0=8'hA5 -> ADDR (load_MAR, bus=8'h12), DATA (load_MDR, bus=8'hA5), ACCESS (CS=1, R_NW=0), done[0]. A RAM model then holds mem[2]=8'hA5.
- Read back: req0, we=0, addr0=5'h12 -> ACCESS with R_NW=1, READ with MDR_bus=1. done[0] pulses with rdata=8'hA5, 4 cycles after grant.
- Tie:
  - req=2'b11 held for three transactions.
  - With MEM_BUS_RR_EN, gnt order is 0, 1, 0.
  - Without the macro, order is 0, 0, 0.
- Mid-op drop: req1 read granted, req1 deasserted during ACCESS -> READ and DONE still occur and done[1] pulses once.
- Reset mid-op: reset=1 during a write's DATA state -> next cycle state=IDLE, all strobes 0, R_NW=1, sysbus=Z, done never pulses. The bus RAM location keeps its old value.
- Bus hygiene: across all above, assert sysbus is driven by the controller only in ADDR/DATA, and load_MAR/load_MDR/CS/MDR_bus are mutually exclusive in every cycle.
